ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage; owns the HI/LO registers.
// Optional early termination of multiplies is enabled by defining MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         cancel,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_next;
  logic           div_q;
  logic           sign_a, sign_b;
  logic [N-1:0]   a_q;      // dividend magnitude, shifted out msb-first
  logic [N-1:0]   b_q;      // multiplier (shifts right) or divisor (static)
  logic [2*N-1:0] acc;      // product, or {remainder, quotient}
  logic [2*N-1:0] mcand;
  logic [CW-1:0]  cnt;

  // Operand magnitudes; op[0]==0 selects the signed variants.
  logic         a_neg, b_neg;
  logic [N-1:0] a_abs, b_abs;

  assign a_neg = ~op[0] & inA[N-1];
  assign b_neg = ~op[0] & inB[N-1];
  assign a_abs = a_neg ? -inA : inA;
  assign b_abs = b_neg ? -inB : inB;

  // One restoring-division step: bring in the next dividend bit and trial-subtract.
  logic [N:0]     rem_shift, diff;
  logic           fits;
  logic [2*N-1:0] div_acc_next, mul_acc_next;

  assign rem_shift    = {acc[2*N-1:N], a_q[N-1]};
  assign diff         = rem_shift - {1'b0, b_q};
  assign fits         = rem_shift >= {1'b0, b_q};
  assign div_acc_next = fits ? {diff[N-1:0], acc[N-2:0], 1'b1}
                             : {rem_shift[N-1:0], acc[N-2:0], 1'b0};
  assign mul_acc_next = b_q[0] ? acc + mcand : acc;

  logic early_out;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = ~div_q & (b_q == '0);
`else
  assign early_out = 1'b0;
`endif

  // Final sign fix-up. A zero divisor leaves the quotient all ones and the
  // remainder equal to |inA|, so restoring the dividend sign yields raw inA.
  logic [2*N-1:0] prod;
  logic [N-1:0]   fix_hi, fix_lo;
  logic           div_zero;

  assign prod     = (sign_a ^ sign_b) ? -acc : acc;
  assign div_zero = (b_q == '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    fix_hi = prod[2*N-1:N];
    fix_lo = prod[N-1:0];
    if (div_q) begin
      fix_hi = sign_a ? -acc[2*N-1:N] : acc[2*N-1:N];
      if (div_zero)
        fix_lo = '1;
      else
        fix_lo = (sign_a ^ sign_b) ? -acc[N-1:0] : acc[N-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; cancel beats start in IDLE and aborts any busy state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !cancel) state_next = CALC;
      CALC: begin
        if (cancel)                                  state_next = IDLE;
        else if (early_out || cnt == CW'(N - 1))     state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath and architectural HI/LO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !cancel) begin
            div_q  <= op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            a_q    <= a_abs;
            b_q    <= b_abs;
            mcand  <= {{N{1'b0}}, a_abs};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!cancel && !early_out) begin
            cnt <= cnt + CW'(1);
            if (div_q) begin
              acc <= div_acc_next;
              a_q <= a_q << 1;
            end else begin
              acc   <= mul_acc_next;
              mcand <= mcand << 1;
              b_q   <= b_q >> 1;
            end
          end
        end
        FIX: begin
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; inputs change on the falling
// edge and outputs are sampled 1ns after the rising edge.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_7X5 = 5;
  localparam int LAT_9X0 = 2;
`else
  localparam int LAT_7X5 = 33;
  localparam int LAT_9X0 = 33;
`endif

  ex_muldiv_unit #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .cancel(cancel),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launch one operation at E0 and watch 40 further edges; the bound also
  // serves as the timeout when done never arrives.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_n, output int done_n);
    @(negedge clock);
    op = o; inA = a; inB = b; start = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    done_n = 0;
    lat    = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock); #1;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = e;
      end
    end
  endtask

  initial begin
    int lat, bn, dn;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    @(negedge clock); reset = 1'b1;

    // multu max x max
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, dn);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    check("multu_max_lat", lat, 33);
    check("multu_max_busy", bn, 33);
    check("multu_max_done", dn, 1);

    // mult -7 x 3
    do_op(2'b00, 32'hFFFF_FFF9, 32'd3, lat, bn, dn);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);

    // divu 100 / 7
    do_op(2'b11, 32'd100, 32'd7, lat, bn, dn);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_lat", lat, 33);

    // div -7 / 2
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bn, dn);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // div overflow
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, dn);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    // Divide by zero, unsigned and signed
    do_op(2'b11, 32'h1234, 32'h0, lat, bn, dn);
    check("divu_zero_hi", hi, 32'h1234);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_lat", lat, 33);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0, lat, bn, dn);
    check("div_zero_hi", hi, 32'hFFFF_FFF9);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);

    // Preload HI/LO
    @(negedge clock); hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clock); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
    @(negedge clock); lo_we = 1'b0;
    #1;
    check("mthi", hi, 32'hAAAA);
    check("mtlo", lo, 32'h5555);

    // multu 2x3, mthi attempted at E5 (ignored), cancel sampled at E11
    @(negedge clock); op = 2'b01; inA = 32'd2; inB = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    dn = 0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clock);
      start  = 1'b0;
      hi_we  = (e == 5);
      wdata  = 32'h1111;
      cancel = (e == 11);
      @(posedge clock); #1;
      if (done) dn++;
      if (e == 10) check("cancel_busy_before", {31'b0, busy}, 32'h1);
    end
    check("cancel_busy_after", {31'b0, busy}, 32'h0);
    @(negedge clock); cancel = 1'b0; hi_we = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done) dn++;
    end
    check("cancel_no_done", dn, 0);
    check("cancel_hi", hi, 32'hAAAA);
    check("cancel_lo", lo, 32'h5555);

    // cancel together with start in IDLE: nothing starts
    @(negedge clock); op = 2'b01; inA = 32'd2; inB = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clock); #1;
    check("cancel_start_busy", {31'b0, busy}, 32'h0);
    @(negedge clock); start = 1'b0; cancel = 1'b0;

    // divu 100/7 with mthi at E0, stray start at E5
    @(negedge clock); op = 2'b11; inA = 32'd100; inB = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h77;
    @(posedge clock); #1;
    check("we_with_start_hi", hi, 32'h77);
    check("we_with_start_busy", {31'b0, busy}, 32'h1);
    dn = 0; lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock);
      hi_we = 1'b0;
      start = (e == 5);
      op    = 2'b01; inA = 32'd3; inB = 32'd3;
      @(posedge clock); #1;
      if (done) begin
        dn++;
        if (lat < 0) lat = e;
      end
    end
    check("busy_start_lat", lat, 33);
    check("busy_start_done", dn, 1);
    check("busy_start_lo", lo, 32'd14);
    check("busy_start_hi", hi, 32'd2);
    check("busy_start_idle", {31'b0, busy}, 32'h0);

    // Reset sampled at E20 of an in-flight divide
    @(negedge clock); op = 2'b11; inA = 32'd100; inB = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clock);
      start = 1'b0;
      reset = (e != 20);
      @(posedge clock); #1;
    end
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    @(negedge clock); reset = 1'b1;

    // Multiply latency depends on the early-out build option
    do_op(2'b01, 32'd7, 32'd5, lat, bn, dn);
    check("multu_7x5_lo", lo, 32'd35);
    check("multu_7x5_hi", hi, 32'd0);
    check("multu_7x5_lat", lat, LAT_7X5);
    do_op(2'b01, 32'd9, 32'd0, lat, bn, dn);
    check("multu_9x0_lo", lo, 32'd0);
    check("multu_9x0_lat", lat, LAT_9X0);
    check("multu_9x0_done", dn, 1);
    do_op(2'b11, 32'd100, 32'd7, lat, bn, dn);
    check("divu_again_lo", lo, 32'd14);
    check("divu_again_lat", lat, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
